// File: rtl/fifo_umbral_param_pkg.sv
// Shared defaults, per-cycle operation decode and pause hysteresis decision
// for the threshold FIFO.
package fifo_umbral_param_pkg;

    localparam int unsigned DEF_BITNUMBER = 8;
    localparam int unsigned DEF_LENGTH    = 8;

    typedef struct packed {
        logic rd_acc;
        logic wr_acc;
        logic overflow;
        logic underflow;
    } fifo_op_t;

    typedef enum logic [1:0] {
        PAUSE_HOLD = 2'd0,
        PAUSE_SET  = 2'd1,
        PAUSE_CLR  = 2'd2
    } pause_act_t;

    // A write may land on a full FIFO only when a read frees a slot in the same cycle;
    // a read+write on an empty FIFO is a plain write, not an underflow.
    function automatic fifo_op_t decode_op(input logic wr, input logic rd,
                                           input logic full, input logic empty);
        fifo_op_t op;
        op.rd_acc    = rd && !empty;
        op.wr_acc    = wr && (!full || op.rd_acc);
        op.overflow  = wr && full && !op.rd_acc;
        op.underflow = rd && empty && !wr;
        return op;
    endfunction

    // Set wins over clear; a zero high threshold disables the set side.
    function automatic pause_act_t pause_decide(input int unsigned nxt,
                                                input int unsigned alto,
                                                input int unsigned bajo);
        if ((alto != 0) && (nxt >= alto))
            return PAUSE_SET;
        else if (nxt <= bajo)
            return PAUSE_CLR;
        else
            return PAUSE_HOLD;
    endfunction

endpackage

// File: rtl/fifo_umbral_param_mem.sv
// Dual-port storage: synchronous write, registered synchronous read.
// Only the read register is reset; the array itself keeps its contents.
module fifo_umbral_param_mem #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    // Same-address read+write (only possible when full) returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            o_rdata <= '0;
        else if (i_re)
            o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/fifo_umbral_param.sv
// Parametrised synchronous FIFO with runtime thresholds, hysteretic pause
// backpressure, occupancy count and sticky over/underflow error.
module fifo_umbral_param
    import fifo_umbral_param_pkg::*;
#(
    parameter int unsigned BITNUMBER = DEF_BITNUMBER,
    parameter int unsigned LENGTH    = DEF_LENGTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          Fifo_wr,
    input  logic                          Fifo_rd,
    input  logic [BITNUMBER-1:0]          Fifo_Data_in,
    input  logic [$clog2(LENGTH):0]       Umbral_alto,
    input  logic [$clog2(LENGTH):0]       Umbral_bajo,
    output logic [BITNUMBER-1:0]          Fifo_Data_out,
    output logic                          Fifo_valid,
    output logic                          Fifo_full,
    output logic                          Fifo_empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic                          pause,
    output logic                          Fifo_error,
    output logic [$clog2(LENGTH):0]       Fifo_count
);

    localparam int unsigned ADDR = $clog2(LENGTH);
    localparam int unsigned CW   = ADDR + 1;

    logic [ADDR-1:0] r_wr_ptr;
    logic [ADDR-1:0] r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_valid;
    logic            r_pause;
    logic            r_error;

    fifo_op_t        w_op;
    logic [CW-1:0]   w_count_nxt;
    pause_act_t      w_pause_act;

    // Flags come straight from the registered count; thresholds are live inputs.
    assign Fifo_full    = (r_count == CW'(LENGTH));
    assign Fifo_empty   = (r_count == '0);
    assign almost_full  = (Umbral_alto != '0) && (r_count >= Umbral_alto);
    assign almost_empty = (r_count <= Umbral_bajo);
    assign Fifo_count   = r_count;
    assign Fifo_valid   = r_valid;
    assign pause        = r_pause;
    assign Fifo_error   = r_error;

    always_comb begin
        w_op        = decode_op(Fifo_wr, Fifo_rd, Fifo_full, Fifo_empty);
        w_count_nxt = r_count;
        if (w_op.wr_acc && !w_op.rd_acc)
            w_count_nxt = r_count + CW'(1);
        else if (w_op.rd_acc && !w_op.wr_acc)
            w_count_nxt = r_count - CW'(1);
        w_pause_act = pause_decide(32'(w_count_nxt), 32'(Umbral_alto), 32'(Umbral_bajo));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_pause  <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            if (w_op.wr_acc)
                r_wr_ptr <= r_wr_ptr + ADDR'(1);
            if (w_op.rd_acc)
                r_rd_ptr <= r_rd_ptr + ADDR'(1);
            r_count <= w_count_nxt;
            r_valid <= w_op.rd_acc;
            if (w_op.overflow || w_op.underflow)
                r_error <= 1'b1;
            case (w_pause_act)
                PAUSE_SET: r_pause <= 1'b1;
                PAUSE_CLR: r_pause <= 1'b0;
                default:   r_pause <= r_pause;
            endcase
        end
    end

    fifo_umbral_param_mem #(
        .W     (BITNUMBER),
        .DEPTH (LENGTH),
        .AW    (ADDR)
    ) u_mem (
        .clk     (clk),
        .rst_n   (reset),
        .i_we    (w_op.wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (Fifo_Data_in),
        .i_re    (w_op.rd_acc),
        .i_raddr (r_rd_ptr),
        .o_rdata (Fifo_Data_out)
    );

endmodule

// File: tb/tb_fifo_umbral_param.sv
// Bench for fifo_umbral_param: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fifo_umbral_param;

    localparam int LEN = 8;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       wr    = 1'b0;
    logic       rd    = 1'b0;
    logic [7:0] din   = 8'h00;
    logic [3:0] alto  = 4'd6;
    logic [3:0] bajo  = 4'd2;

    logic [7:0] dout;
    logic       valid, full, empty, afull, aempty, pause_o, err;
    logic [3:0] count;

    int checks = 0;
    int errors = 0;

    always #4 clk = ~clk;

    fifo_umbral_param #(.BITNUMBER(8), .LENGTH(LEN)) dut (
        .clk           (clk),
        .reset         (reset),
        .Fifo_wr       (wr),
        .Fifo_rd       (rd),
        .Fifo_Data_in  (din),
        .Umbral_alto   (alto),
        .Umbral_bajo   (bajo),
        .Fifo_Data_out (dout),
        .Fifo_valid    (valid),
        .Fifo_full     (full),
        .Fifo_empty    (empty),
        .almost_full   (afull),
        .almost_empty  (aempty),
        .pause         (pause_o),
        .Fifo_error    (err),
        .Fifo_count    (count)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word queue plus the few registered outputs.
    logic [7:0] mq[$];
    logic [7:0] m_dout  = 8'h00;
    bit         m_valid = 1'b0;
    bit         m_pause = 1'b0;
    bit         m_err   = 1'b0;
    int         m_n0;
    bit         m_rok, m_wok;

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                mq.delete();
                m_dout  = 8'h00;
                m_valid = 1'b0;
                m_pause = 1'b0;
                m_err   = 1'b0;
            end else begin
                m_n0  = mq.size();
                m_rok = rd && (m_n0 > 0);
                m_wok = wr && ((m_n0 < LEN) || m_rok);
                if (wr && (m_n0 == LEN) && !m_rok) m_err = 1'b1;
                if (rd && (m_n0 == 0) && !wr)      m_err = 1'b1;
                m_valid = m_rok;
                if (m_rok) m_dout = mq.pop_front();
                if (m_wok) mq.push_back(din);
                if ((alto != 0) && (mq.size() >= int'(alto)))
                    m_pause = 1'b1;
                else if (mq.size() <= int'(bajo))
                    m_pause = 1'b0;
            end
        end
    end

    // Every-cycle comparison, on the falling edge, away from the sampling edge.
    initial begin
        int n;
        forever begin
            @(negedge clk);
            n = mq.size();
            check("cmp_dout",   int'(dout),    int'(m_dout));
            check("cmp_valid",  int'(valid),   int'(m_valid));
            check("cmp_count",  int'(count),   n);
            check("cmp_full",   int'(full),    int'(n == LEN));
            check("cmp_empty",  int'(empty),   int'(n == 0));
            check("cmp_afull",  int'(afull),   int'((alto != 0) && (n >= int'(alto))));
            check("cmp_aempty", int'(aempty),  int'(n <= int'(bajo)));
            check("cmp_pause",  int'(pause_o), int'(m_pause));
            check("cmp_error",  int'(err),     int'(m_err));
        end
    end

    task automatic step(input logic w, input logic r, input logic [7:0] d);
        @(negedge clk);
        #1;
        wr  = w;
        rd  = r;
        din = d;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] abcd [4];
        logic [7:0] held;
        int wp;
        abcd = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};

        repeat (3) @(negedge clk);
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_dout",  int'(dout),  0);
        check("rst_flags", int'({valid, pause_o, err, full}), 0);
        #1 reset = 1'b1;

        // Four writes then one read returns the first word with a one-cycle strobe.
        foreach (abcd[i]) step(1'b1, 1'b0, abcd[i]);
        step(1'b0, 1'b0, 8'h00);
        settle();
        check("t1_count4", int'(count), 4);
        step(1'b0, 1'b1, 8'h00);
        settle();
        check("t1_dout", int'(dout), 8'h0A);
        check("t1_valid", int'(valid), 1);
        step(1'b0, 1'b0, 8'h00);
        settle();
        check("t1_valid_drop", int'(valid), 0);
        check("t1_dout_hold", int'(dout), 8'h0A);
        repeat (3) step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        settle();
        check("t1_last", int'(dout), 8'h0D);
        check("t1_empty", int'(empty), 1);

        // Fill, overflow, drain in order.
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 8'(i));
        step(1'b0, 1'b0, 8'h00);
        settle();
        check("t2_full", int'(full), 1);
        check("t2_err_before", int'(err), 0);
        step(1'b1, 1'b0, 8'h09);
        step(1'b0, 1'b0, 8'h00);
        settle();
        check("t2_ovf_count", int'(count), 8);
        check("t2_ovf_err", int'(err), 1);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, 8'h00);
            settle();
            check("t2_drain", int'(dout), i);
        end
        step(1'b0, 1'b0, 8'h00);

        // Pause hysteresis with alto=6, bajo=2.
        pulse_reset();
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 8'(i));
        step(1'b0, 1'b0, 8'h00);
        settle();
        check("t3_pause_at5", int'(pause_o), 0);
        step(1'b1, 1'b0, 8'h06);
        step(1'b0, 1'b0, 8'h00);
        settle();
        check("t3_pause_at6", int'(pause_o), 1);
        check("t3_afull_at6", int'(afull), 1);
        repeat (3) step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        settle();
        check("t3_count3", int'(count), 3);
        check("t3_pause_at3", int'(pause_o), 1);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        settle();
        check("t3_pause_at2", int'(pause_o), 0);

        // Full with simultaneous read+write, then empty with simultaneous read+write.
        for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
        step(1'b1, 1'b1, 8'h0F);
        step(1'b0, 1'b0, 8'h00);
        settle();
        check("t4_full_rw_count", int'(count), 8);
        check("t4_full_rw_err", int'(err), 0);
        repeat (8) step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        settle();
        check("t4_last_0F", int'(dout), 8'h0F);
        check("t4_drained", int'(empty), 1);
        step(1'b1, 1'b1, 8'h0F);
        settle();
        check("t4_empty_rw_count", int'(count), 1);
        check("t4_empty_rw_valid", int'(valid), 0);
        check("t4_empty_rw_err", int'(err), 0);
        step(1'b0, 1'b1, 8'h00);
        settle();
        check("t4_readback", int'(dout), 8'h0F);

        // Underflow leaves the output word untouched.
        held = dout;
        step(1'b0, 1'b1, 8'h00);
        settle();
        check("t5_udf_err", int'(err), 1);
        check("t5_udf_dout", int'(dout), int'(held));
        check("t5_udf_valid", int'(valid), 0);

        // 20 streamed words wrap the pointers twice and come back in order.
        step(1'b1, 1'b0, 8'h20);
        for (int k = 1; k < 20; k++) begin
            step(1'b1, 1'b1, 8'(8'h20 + k));
            settle();
            check("t6_stream", int'(dout), 8'h20 + k - 1);
        end
        step(1'b0, 1'b1, 8'h00);
        settle();
        check("t6_stream_last", int'(dout), 8'h33);
        step(1'b0, 1'b0, 8'h00);

        // Asynchronous reset mid-fill.
        alto = 4'd4;
        bajo = 4'd1;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
        step(1'b0, 1'b0, 8'h00);
        settle();
        check("t7_count5", int'(count), 5);
        check("t7_pause_pre", int'(pause_o), 1);
        reset = 1'b0;
        #1;
        check("t7_rst_count", int'(count), 0);
        check("t7_rst_empty", int'(empty), 1);
        check("t7_rst_pause", int'(pause_o), 0);
        check("t7_rst_err", int'(err), 0);
        check("t7_rst_dout", int'(dout), 0);
        @(negedge clk);
        #1 reset = 1'b1;

        // Randomized traffic with legal thresholds and occasional resets.
        wp = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                alto = 4'($urandom_range(0, 8));
                bajo = (alto == 0) ? 4'($urandom_range(0, 8))
                                   : 4'($urandom_range(0, int'(alto) - 1));
                wp   = int'($urandom_range(20, 80));
            end
            step(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < (100 - wp)),
                 8'($urandom));
            if (c % 700 == 699) pulse_reset();
        end
        step(1'b0, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
